// File: rtl/sensor_sched_pkg.sv
// sensor_sched_pkg: command codes, response codes and FSM states shared by the sensor request scheduler
package sensor_sched_pkg;
  localparam logic [7:0] CMD_STATUS    = 8'h00;
  localparam logic [7:0] CMD_READ_TEMP = 8'h01;
  localparam logic [7:0] CMD_READ_HUM  = 8'h02;
  localparam logic [7:0] CMD_CONT_TEMP = 8'h03;
  localparam logic [7:0] CMD_CONT_HUM  = 8'h04;
  localparam logic [7:0] CMD_STOP_CONT = 8'h05;
  localparam logic [7:0] RSP_OK        = 8'h07;
  localparam logic [7:0] RSP_HUM       = 8'h08;
  localparam logic [7:0] RSP_TEMP      = 8'h09;
  localparam logic [7:0] RSP_CONT_STOP = 8'h0A;
  localparam logic [7:0] RSP_ERR       = 8'h1F;
  localparam logic [7:0] RSP_BAD_ADDR  = 8'hFE;
  localparam logic [7:0] RSP_BAD_CMD   = 8'hFF;
  typedef enum logic [2:0] {
    IDLE, DECODE, START, WAIT, TX_CODE, TX_CODE_WAIT, TX_VAL, TX_VAL_WAIT
  } state_t;
endpackage

// File: rtl/sensor_request_scheduler_cycle_timer.sv
// cycle_timer: down-counter reloaded to CYCLES-1 by load or on expiry; expire pulses when it hits zero while enabled (i_Clock, i_Reset_n, load, en -> expire)
module cycle_timer #(
  parameter int CYCLES = 100
) (
  input  logic i_Clock,
  input  logic i_Reset_n,
  input  logic load,
  input  logic en,
  output logic expire
);
  localparam int W = CYCLES > 1 ? $clog2(CYCLES) : 1;
  localparam logic [W-1:0] TOP = W'(CYCLES - 1);
  logic [W-1:0] cnt;
  assign expire = en && !load && cnt == '0;
  always_ff @(posedge i_Clock or negedge i_Reset_n)
    if (!i_Reset_n) cnt <= '0;
    else if (load || expire) cnt <= TOP;
    else if (en) cnt <= cnt - 1'b1;
endmodule

// File: rtl/sensor_request_scheduler.sv
// sensor_request_scheduler: takes (i_Address,i_Request) on i_Req_Valid, pulses o_Start[addr], waits for i_Done/i_Error/timeout, sends code+value via o_Tx_Data/o_Tx_Start/i_Tx_Done; `CONTINUOUS_MODE_EN builds periodic re-issue
module sensor_request_scheduler
  import sensor_sched_pkg::*;
#(
  parameter int NUM_SENSORS        = 32,
  parameter int TIMEOUT_CYCLES     = 5_000_000,
  parameter int CONT_PERIOD_CYCLES = 50_000_000
) (
  input  logic                      i_Clock,
  input  logic                      i_Reset_n,
  input  logic [7:0]                i_Address,
  input  logic [7:0]                i_Request,
  input  logic                      i_Req_Valid,
  output logic                      o_Req_Ready,
  output logic [NUM_SENSORS-1:0]    o_Start,
  input  logic [NUM_SENSORS-1:0]    i_Done,
  input  logic [NUM_SENSORS-1:0]    i_Error,
  input  logic [16*NUM_SENSORS-1:0] i_Data,
  output logic [7:0]                o_Tx_Data,
  output logic                      o_Tx_Start,
  input  logic                      i_Tx_Done,
  output logic                      o_Busy
);
  localparam int AW = NUM_SENSORS > 1 ? $clog2(NUM_SENSORS) : 1;
  state_t state, state_d;
  logic [7:0] addr_q, addr_d, cmd_q, cmd_d, code_q, code_d, val_q, val_d;
  logic [AW-1:0] sel;
  logic [15:0] data;
  logic bad_addr, bad_cmd, is_hum, to_exp;
  assign sel      = addr_q[AW-1:0];
  assign data     = i_Data[16*sel +: 16];
  assign bad_addr = 32'(addr_q) >= NUM_SENSORS;
  assign is_hum   = cmd_q == CMD_READ_HUM || cmd_q == CMD_CONT_HUM;
`ifdef CONTINUOUS_MODE_EN
  assign bad_cmd  = cmd_q > CMD_STOP_CONT;
  logic cont_q, cont_hum_q, pend_q, per_exp, svc, cont_set, cont_clr;
  logic [7:0] cont_addr_q;
  cycle_timer #(.CYCLES(CONT_PERIOD_CYCLES)) u_period (
    .i_Clock(i_Clock), .i_Reset_n(i_Reset_n), .load(cont_set), .en(cont_q), .expire(per_exp)
  );
  // A stop wins over a coincident expiry; a new expiry wins over the service that clears the flag.
  always_ff @(posedge i_Clock or negedge i_Reset_n)
    if (!i_Reset_n) begin
      cont_q      <= 1'b0;
      cont_hum_q  <= 1'b0;
      cont_addr_q <= '0;
      pend_q      <= 1'b0;
    end else begin
      cont_q      <= cont_set ? 1'b1 : cont_clr ? 1'b0 : cont_q;
      cont_hum_q  <= cont_set ? cmd_q == CMD_CONT_HUM : cont_hum_q;
      cont_addr_q <= cont_set ? addr_q : cont_addr_q;
      pend_q      <= cont_clr ? 1'b0 : per_exp ? 1'b1 : svc ? 1'b0 : pend_q;
    end
`else
  assign bad_cmd  = cmd_q > CMD_READ_HUM;
`endif
  cycle_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .i_Clock(i_Clock), .i_Reset_n(i_Reset_n), .load(state == START), .en(state == WAIT), .expire(to_exp)
  );
  always_ff @(posedge i_Clock or negedge i_Reset_n)
    if (!i_Reset_n) begin
      state  <= IDLE;
      addr_q <= '0;
      cmd_q  <= '0;
      code_q <= '0;
      val_q  <= '0;
    end else begin
      state  <= state_d;
      addr_q <= addr_d;
      cmd_q  <= cmd_d;
      code_q <= code_d;
      val_q  <= val_d;
    end
  always_comb begin
    state_d = state;
    addr_d  = addr_q;
    cmd_d   = cmd_q;
    code_d  = code_q;
    val_d   = val_q;
`ifdef CONTINUOUS_MODE_EN
    svc      = 1'b0;
    cont_set = 1'b0;
    cont_clr = 1'b0;
`endif
    case (state)
      IDLE:
        if (i_Req_Valid) begin
          addr_d  = i_Address;
          cmd_d   = i_Request;
          state_d = DECODE;
        end
`ifdef CONTINUOUS_MODE_EN
        else if (pend_q) begin
          addr_d  = cont_addr_q;
          cmd_d   = cont_hum_q ? CMD_READ_HUM : CMD_READ_TEMP;
          svc     = 1'b1;
          state_d = DECODE;
        end
`endif
      DECODE:
        if (bad_addr || bad_cmd) begin
          code_d  = bad_addr ? RSP_BAD_ADDR : RSP_BAD_CMD;
          val_d   = 8'h00;
          state_d = TX_CODE;
        end
`ifdef CONTINUOUS_MODE_EN
        else if (cmd_q == CMD_STOP_CONT) begin
          code_d   = RSP_CONT_STOP;
          val_d    = 8'h00;
          cont_clr = 1'b1;
          state_d  = TX_CODE;
        end else begin
          cont_set = cmd_q == CMD_CONT_TEMP || cmd_q == CMD_CONT_HUM;
          state_d  = START;
        end
`else
        else state_d = START;
`endif
      START: state_d = WAIT;
      WAIT:
        if (i_Error[sel] || to_exp) begin
          code_d  = RSP_ERR;
          val_d   = 8'h00;
          state_d = TX_CODE;
        end else if (i_Done[sel]) begin
          code_d  = cmd_q == CMD_STATUS ? RSP_OK : is_hum ? RSP_HUM : RSP_TEMP;
          val_d   = cmd_q == CMD_STATUS ? 8'h00 : is_hum ? data[15:8] : data[7:0];
          state_d = TX_CODE;
        end
      TX_CODE:      state_d = TX_CODE_WAIT;
      TX_CODE_WAIT: state_d = i_Tx_Done ? TX_VAL : TX_CODE_WAIT;
      TX_VAL:       state_d = TX_VAL_WAIT;
      TX_VAL_WAIT:  state_d = i_Tx_Done ? IDLE : TX_VAL_WAIT;
      default:      state_d = IDLE;
    endcase
  end
  assign o_Req_Ready = state == IDLE;
  assign o_Busy      = state != IDLE;
  assign o_Start     = state == START ? NUM_SENSORS'(1) << sel : '0;
  assign o_Tx_Start  = state == TX_CODE || state == TX_VAL;
  assign o_Tx_Data   = (state == TX_VAL || state == TX_VAL_WAIT) ? val_q :
                       (state == TX_CODE || state == TX_CODE_WAIT) ? code_q : 8'h00;
endmodule

// File: tb/tb_sensor_request_scheduler.sv
// tb_sensor_request_scheduler: vector table plus scoreboard of expected TX bytes, with timeout, drop, continuous and reset sequences
module tb_sensor_request_scheduler;
  localparam int NS = 32;
  logic i_Clock = 1'b0;
  logic i_Reset_n;
  logic [7:0] i_Address, i_Request;
  logic i_Req_Valid;
  logic o_Req_Ready;
  logic [NS-1:0] o_Start, i_Done, i_Error;
  logic [16*NS-1:0] i_Data;
  logic [7:0] o_Tx_Data;
  logic o_Tx_Start, i_Tx_Done, o_Busy;
  sensor_request_scheduler #(.NUM_SENSORS(NS), .TIMEOUT_CYCLES(100), .CONT_PERIOD_CYCLES(200)) dut (
    .i_Clock(i_Clock), .i_Reset_n(i_Reset_n), .i_Address(i_Address), .i_Request(i_Request),
    .i_Req_Valid(i_Req_Valid), .o_Req_Ready(o_Req_Ready), .o_Start(o_Start), .i_Done(i_Done),
    .i_Error(i_Error), .i_Data(i_Data), .o_Tx_Data(o_Tx_Data), .o_Tx_Start(o_Tx_Start),
    .i_Tx_Done(i_Tx_Done), .o_Busy(o_Busy)
  );
  always #5 i_Clock = ~i_Clock;
  int total = 0, bad = 0, cyc = 0;
  bit tx_en = 1'b1;
  logic [7:0] exp_q[$];
  always @(posedge i_Clock) cyc++;
  typedef struct {
    logic [7:0]  addr, cmd;
    logic [1:0]  resp;
    logic [15:0] data;
    logic [7:0]  code, val;
    logic        start;
  } vec_t;
  vec_t vecs[$];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  initial begin : tx_side
    logic [7:0] last;
    i_Tx_Done = 1'b0;
    forever begin
      @(negedge i_Clock);
      if (tx_en) i_Tx_Done = 1'b0;
      if (tx_en && i_Reset_n && o_Tx_Start) begin
        if (exp_q.size() == 0) check("tx_unexpected", 32'(o_Tx_Data), 32'hDEAD);
        else begin
          last = exp_q.pop_front();
          check("tx_byte", 32'(o_Tx_Data), 32'(last));
          @(negedge i_Clock);
          check("tx_hold", 32'(o_Tx_Data), 32'(last));
        end
        @(negedge i_Clock);
        i_Tx_Done = 1'b1;
      end
    end
  end
  task automatic wait_idle();
    for (int i = 0; i < 60 && !o_Req_Ready; i++) @(negedge i_Clock);
    check("idle_reached", 32'(o_Req_Ready), 32'd1);
  endtask
  task automatic rand_data();
    for (int i = 0; i < NS; i++) i_Data[i*16 +: 16] = 16'($urandom);
  endtask
  task automatic do_req(input vec_t v);
    logic [NS-1:0] mask;
    mask = NS'(1) << v.addr[4:0];
    exp_q.push_back(v.code);
    exp_q.push_back(v.val);
    i_Address = v.addr;
    i_Request = v.cmd;
    i_Req_Valid = 1'b1;
    @(negedge i_Clock);
    i_Req_Valid = 1'b0;
    @(negedge i_Clock);
    check("start_onehot", o_Start, v.start ? mask : '0);
    if (v.start) begin
      @(negedge i_Clock);
      check("start_pulse", o_Start, '0);
      rand_data();
      i_Done = ~mask;
      i_Error = ~mask;
      @(negedge i_Clock);
      check("other_sensors_ignored", 32'(o_Tx_Start), 32'd0);
      i_Done = v.resp[0] ? mask : '0;
      i_Error = v.resp[1] ? mask : '0;
      i_Data[int'(v.addr[4:0])*16 +: 16] = v.data;
      @(negedge i_Clock);
      i_Done = '0;
      i_Error = '0;
      check("tx_latency", 32'(o_Tx_Start), 32'd1);
    end
    wait_idle();
    check("sb_drain", 32'(exp_q.size()), 32'd0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  initial begin
    int n, t[3];
    vecs.push_back('{8'h03, 8'h01, 2'b01, 16'h4119, 8'h09, 8'h19, 1'b1});
    vecs.push_back('{8'h00, 8'h00, 2'b10, 16'h0000, 8'h1F, 8'h00, 1'b1});
    vecs.push_back('{8'h07, 8'h00, 2'b01, 16'hABCD, 8'h07, 8'h00, 1'b1});
    vecs.push_back('{8'h1F, 8'h02, 2'b01, 16'h4119, 8'h08, 8'h41, 1'b1});
    vecs.push_back('{8'h10, 8'h01, 2'b01, 16'h5AC3, 8'h09, 8'hC3, 1'b1});
    vecs.push_back('{8'h1F, 8'h01, 2'b11, 16'h2233, 8'h1F, 8'h00, 1'b1});
    vecs.push_back('{8'h40, 8'h01, 2'b00, 16'h0000, 8'hFE, 8'h00, 1'b0});
    vecs.push_back('{8'h01, 8'h33, 2'b00, 16'h0000, 8'hFF, 8'h00, 1'b0});
    vecs.push_back('{8'h20, 8'h33, 2'b00, 16'h0000, 8'hFE, 8'h00, 1'b0});
    vecs.push_back('{8'h05, 8'h06, 2'b00, 16'h0000, 8'hFF, 8'h00, 1'b0});
`ifndef CONTINUOUS_MODE_EN
    vecs.push_back('{8'h02, 8'h03, 2'b00, 16'h0000, 8'hFF, 8'h00, 1'b0});
    vecs.push_back('{8'h02, 8'h04, 2'b00, 16'h0000, 8'hFF, 8'h00, 1'b0});
    vecs.push_back('{8'h02, 8'h05, 2'b00, 16'h0000, 8'hFF, 8'h00, 1'b0});
`endif
    i_Reset_n = 1'b0;
    i_Address = '0;
    i_Request = '0;
    i_Req_Valid = 1'b0;
    i_Done = '0;
    i_Error = '0;
    i_Data = '0;
    repeat (3) @(negedge i_Clock);
    check("rst_start", o_Start, '0);
    check("rst_tx_data", 32'(o_Tx_Data), 32'd0);
    check("rst_tx_start", 32'(o_Tx_Start), 32'd0);
    check("rst_busy", 32'(o_Busy), 32'd0);
    check("rst_ready", 32'(o_Req_Ready), 32'd1);
    i_Reset_n = 1'b1;
    @(negedge i_Clock);
    foreach (vecs[i]) do_req(vecs[i]);
    exp_q.push_back(8'h1F);
    exp_q.push_back(8'h00);
    i_Address = 8'h05;
    i_Request = 8'h02;
    i_Req_Valid = 1'b1;
    @(negedge i_Clock);
    i_Req_Valid = 1'b0;
    @(negedge i_Clock);
    check("timeout_start", o_Start, 32'h20);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge i_Clock);
      if (o_Tx_Start) break;
      n++;
    end
    check("timeout_wait_cycles", n, 100);
    wait_idle();
    check("timeout_drain", 32'(exp_q.size()), 32'd0);
    exp_q.push_back(8'h1F);
    exp_q.push_back(8'h00);
    i_Address = 8'h00;
    i_Request = 8'h00;
    i_Req_Valid = 1'b1;
    @(negedge i_Clock);
    i_Req_Valid = 1'b0;
    repeat (2) @(negedge i_Clock);
    i_Error = 32'h1;
    @(negedge i_Clock);
    i_Error = '0;
    check("drop_ready_low", 32'(o_Req_Ready), 32'd0);
    i_Address = 8'h04;
    i_Request = 8'h01;
    i_Req_Valid = 1'b1;
    @(negedge i_Clock);
    i_Req_Valid = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge i_Clock);
      if (|o_Start) n++;
    end
    check("drop_no_start", n, 0);
    check("drop_drain", 32'(exp_q.size()), 32'd0);
`ifdef CONTINUOUS_MODE_EN
    i_Data[2*16 +: 16] = 16'h5512;
    exp_q.push_back(8'h08);
    exp_q.push_back(8'h55);
    i_Address = 8'h02;
    i_Request = 8'h04;
    i_Req_Valid = 1'b1;
    @(negedge i_Clock);
    i_Req_Valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 400 && !o_Start[2]; i++) @(negedge i_Clock);
      check("cont_start", 32'(o_Start), 32'h4);
      t[k] = cyc;
      if (k > 0) begin
        exp_q.push_back(8'h08);
        exp_q.push_back(8'h55);
      end
      @(negedge i_Clock);
      i_Done = 32'h4;
      @(negedge i_Clock);
      i_Done = '0;
      wait_idle();
    end
    check("cont_period", t[2] - t[1], 200);
    check("cont_drain", 32'(exp_q.size()), 32'd0);
    exp_q.push_back(8'h0A);
    exp_q.push_back(8'h00);
    i_Address = 8'h02;
    i_Request = 8'h05;
    i_Req_Valid = 1'b1;
    @(negedge i_Clock);
    i_Req_Valid = 1'b0;
    n = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge i_Clock);
      if (|o_Start) n++;
    end
    check("cont_stop_no_start", n, 0);
    check("cont_stop_drain", 32'(exp_q.size()), 32'd0);
`endif
    tx_en = 1'b0;
    i_Address = 8'h03;
    i_Request = 8'h01;
    i_Req_Valid = 1'b1;
    @(negedge i_Clock);
    i_Req_Valid = 1'b0;
    @(negedge i_Clock);
    check("mid_start", o_Start, 32'h8);
    @(negedge i_Clock);
    i_Done = 32'h8;
    i_Data[3*16 +: 16] = 16'h1234;
    @(negedge i_Clock);
    i_Done = '0;
    check("mid_code_start", 32'(o_Tx_Start), 32'd1);
    check("mid_code", 32'(o_Tx_Data), 32'h09);
    @(negedge i_Clock);
    i_Tx_Done = 1'b1;
    @(negedge i_Clock);
    i_Tx_Done = 1'b0;
    check("mid_val", 32'(o_Tx_Data), 32'h34);
    @(negedge i_Clock);
    check("mid_busy", 32'(o_Busy), 32'd1);
    i_Reset_n = 1'b0;
    @(negedge i_Clock);
    check("mid_rst_start", o_Start, '0);
    check("mid_rst_tx_data", 32'(o_Tx_Data), 32'd0);
    check("mid_rst_tx_start", 32'(o_Tx_Start), 32'd0);
    check("mid_rst_busy", 32'(o_Busy), 32'd0);
    check("mid_rst_ready", 32'(o_Req_Ready), 32'd1);
    i_Reset_n = 1'b1;
    tx_en = 1'b1;
    @(negedge i_Clock);
    do_req(vecs[0]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sensor_request_scheduler.md
# sensor_request_scheduler

Controller between the UART command path and the per-sensor interface blocks. It accepts a decoded (address, command) byte pair and starts exactly one sensor interface. It waits for that interface's completion, error or a timeout, then sequences a two-byte response (code, value) into the UART transmitter. It also owns an optional continuous-monitoring mode that re-issues a stored request periodically.

## Interface
- NUM_SENSORS, 32: number of sensor interfaces; valid addresses are 0..NUM_SENSORS-1
- TIMEOUT_CYCLES, 5_000_000: clock cycles allowed in WAIT before the request is declared failed
- CONT_PERIOD_CYCLES, 50_000_000: continuous re-issue period in cycles
- i_Clock  in  1  system clock; all logic on the rising edge
- i_Reset_n  in  1  asynchronous, active-low reset
- i_Address  in  8  sensor address, valid with i_Req_Valid
- i_Request  in  8  command code, valid with i_Req_Valid
- i_Req_Valid  in  1  one-cycle pulse: pair complete
- o_Req_Ready  out  1  high only in IDLE
- o_Start  out  NUM_SENSORS  one-hot start pulse to the selected sensor interface
- i_Done  in  NUM_SENSORS  per-sensor measurement-complete pulse
- i_Error  in  NUM_SENSORS  per-sensor failure pulse
- i_Data  in  16*NUM_SENSORS  per-sensor result: [15:8] humidity integer, [7:0] temperature integer
- o_Tx_Data  out  8  byte to the UART transmitter
- o_Tx_Start  out  1  one-cycle pulse: transmit o_Tx_Data
- i_Tx_Done  in  1  transmitter finished the current byte
- o_Busy  out  1  high in every state except IDLE

## Operation
- Commands:
  - 0x00 status
  - 0x01 read temperature
  - 0x02 read humidity
  - 0x03 continuous temperature
  - 0x04 continuous humidity
  - 0x05 stop continuous
- Response codes:
  - 0x07 sensor OK
  - 0x09 temperature
  - 0x08 humidity
  - 0x1F sensor error/timeout
  - 0x0A continuous stopped
  - 0xFE bad address
  - 0xFF bad command
- States: IDLE, DECODE, START, WAIT, TX_CODE, TX_CODE_WAIT, TX_VAL, TX_VAL_WAIT.
- IDLE → DECODE: on i_Req_Valid, latch address and command. While not in IDLE, i_Req_Valid is ignored and dropped.
- DECODE → TX_CODE: for a bad address (≥ NUM_SENSORS) or bad command; value byte 0x00. Bad address takes priority.
- DECODE → TX_CODE: for command 0x05; clears continuous mode; response 0x0A, 0x00.
- DECODE → START: for all other commands. Commands 0x03/0x04 also store address and kind, set continuous mode, and restart the period counter.
- START: o_Start[addr] = 1 for exactly one cycle → WAIT; timeout counter cleared.
- WAIT: i_Error[addr] or counter = TIMEOUT_CYCLES-1 → response (0x1F, 0x00). i_Done[addr] → response from the command:
  - status: (0x07, 0x00)
  - temperature: (0x09, data[7:0])
  - humidity: (0x08, data[15:8])
- WAIT priority: if i_Error and i_Done arrive in the same cycle, error wins. Done/error bits of non-selected sensors are ignored.
- TX_CODE: drive o_Tx_Data = code, pulse o_Tx_Start for one cycle → TX_CODE_WAIT. TX_VAL/TX_VAL_WAIT do the same for the value byte. i_Tx_Done advances each WAIT state; after the value byte, return to IDLE.
- Continuous mode: the period counter runs while the mode is set. On expiry a pending flag is set. In IDLE with the flag set, the stored request runs as a read (0x01/0x02 path) and the flag clears.
- Simultaneous events: i_Req_Valid in the same cycle as a pending flag means the host wins; the flag stays set and is serviced at the next IDLE. Repeated expiries while pending do not queue; one flag only.

## Timing
- Reset values:
  - o_Start = 0, o_Tx_Data = 0x00, o_Tx_Start = 0, o_Busy = 0, o_Req_Ready = 1
  - continuous mode off; pending flag and all counters at 0; state IDLE
- Reset mid-operation: immediate return to IDLE; no partial response is completed.
- i_Req_Valid at edge N: o_Start pulses in cycle N+2.
- i_Done at edge M: o_Tx_Start pulses in cycle M+1.
- Error paths (bad address, bad command, 0x05): o_Tx_Start in cycle N+2.
- o_Tx_Data is held stable from the o_Tx_Start pulse until the matching i_Tx_Done.
- Counters wrap to 0 on expiry and never overflow; widths are $clog2 of their parameter.

## Configuration
- CONTINUOUS_MODE_EN defined: commands 0x03–0x05, the period counter and the pending flag are built.
- CONTINUOUS_MODE_EN undefined: 0x03, 0x04 and 0x05 decode as bad commands (0xFF, 0x00); no period logic is present.

## Structure
- Package sensor_sched_pkg holds the command codes, response codes and the state enum.
- One sub-module, cycle_timer: loadable down-counter with an expiry pulse. It is instantiated twice, for the timeout and for the period.

## Test plan
- Request (0x03 addr, 0x01), sensor 3 pulses i_Done with i_Data = 0x4119 → o_Start[3] one pulse; TX bytes 0x09 then 0x19.
- Request (0x00, 0x00), i_Error[0] pulses → TX 0x1F, 0x00; a second request during TX is dropped, with no extra o_Start.
- Request (0x05, 0x02), sensor never responds, TIMEOUT_CYCLES=100 → TX 0x1F, 0x00 exactly 100 cycles after START.
- Request (0x40, 0x01) → TX 0xFE, 0x00 with no o_Start. Request (0x01, 0x33) → TX 0xFF, 0x00.
- CONTINUOUS_MODE_EN set, CONT_PERIOD_CYCLES=200, request (0x02, 0x04) → humidity response repeats every period. (0x02, 0x05) → TX 0x0A, 0x00, after which no further starts occur.
- Assert i_Reset_n low during TX_VAL_WAIT → all outputs at reset values next cycle; the next request behaves normally.
